// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache (one word per line).
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int SET_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [31:0]           A,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [1:0]            o_dbg_state
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int LINES = 1 << SET_BITS;
  localparam int TAG_W = 30 - SET_BITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_valid [LINES];
  logic [TAG_W-1:0]      r_tag   [LINES];
  logic [DATA_WIDTH-1:0] r_data  [LINES];

  logic [SET_BITS-1:0] w_index;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;
  logic                w_load;
  logic                w_fill;
  logic                w_merge;

  assign w_index     = A[SET_BITS+1:2];
  assign w_tag       = A[31:SET_BITS+2];
  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_load      = cpu_re && !cpu_we;
  assign o_dbg_state = r_state;

  function automatic logic [DATA_WIDTH-1:0] fmt_load(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            lane,
    input logic [2:0]            f3
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  fmt_load = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  fmt_load = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b010:  fmt_load = word;
      3'b100:  fmt_load = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  fmt_load = {{(DATA_WIDTH-16){1'b0}}, h};
      default: fmt_load = '0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_store(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] wd,
    input logic [1:0]            lane,
    input logic [2:0]            f3
  );
    merge_store = old;
    case (f3)
      3'b000: begin
        case (lane)
          2'd0:    merge_store[7:0]   = wd[7:0];
          2'd1:    merge_store[15:8]  = wd[7:0];
          2'd2:    merge_store[23:16] = wd[7:0];
          default: merge_store[31:24] = wd[7:0];
        endcase
      end
      3'b001: begin
        if (lane[1]) merge_store[31:16] = wd[15:0];
        else         merge_store[15:0]  = wd[15:0];
      end
      3'b010:  merge_store = wd;
      default: merge_store = old;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Memory handshake: mem_req rises with address/data/funct3 already valid and
  // holds them unchanged until the single-cycle mem_ready pulse; the cycle that
  // carries mem_ready completes the access and releases the pipeline.
  always_comb begin
    w_next     = r_state;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = '0;
    RD         = '0;
    w_fill     = 1'b0;
    w_merge    = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (cpu_we) begin
            stall  = 1'b1;
            w_next = S_WRITE;
          end else if (cpu_re) begin
            if (w_hit) begin
              RD = fmt_load(r_data[w_index], A[1:0], funct3);
            end else begin
              stall  = 1'b1;
              w_next = S_REFILL;
            end
          end
        end
        S_REFILL: begin
          mem_req    = 1'b1;
          mem_addr   = {A[31:2], 2'b00};
          mem_funct3 = 3'b010;
          stall      = !mem_ready;
          if (mem_ready) begin
            RD     = fmt_load(mem_rdata, A[1:0], funct3);
            w_fill = 1'b1;
            w_next = S_IDLE;
          end
        end
        S_WRITE: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = A;
          mem_wdata  = WD;
          mem_funct3 = funct3;
          stall      = !mem_ready;
          if (mem_ready) begin
            w_merge = w_hit;
            w_next  = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) r_valid[i] <= 1'b0;
    end else if (w_fill) begin
      r_valid[w_index] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is never read while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_index]  <= w_tag;
      r_data[w_index] <= mem_rdata;
    end else if (w_merge) begin
      r_data[w_index] <= merge_store(r_data[w_index], WD, A[1:0], funct3);
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (r_state == S_IDLE && w_load) begin
      if (w_hit) hit_count  <= hit_count + 32'd1;
      else       miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Randomized self-checking bench for data_cache: per-cycle expectations from a
// word-level cache/memory model, plus literal directed cases.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_re = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] WD = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] RD;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [1:0]  o_dbg_state;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  data_cache dut (
    .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .A(A), .WD(WD),
    .funct3(funct3), .RD(RD), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .o_dbg_state(o_dbg_state)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // model: which word addresses are cached, and the backing memory contents
  logic        m_valid [8];
  logic [29:0] m_waddr [8];
  logic [31:0] mem_m [logic [29:0]];
  int          m_hits = 0;
  int          m_misses = 0;

  // expectation word: {full, stall, req, we, addr, wdata, f3, rd}
  localparam int EW = 103;
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [EW-1:0] mk(bit full, bit st, bit rq, bit w,
    logic [31:0] ad, logic [31:0] wd, logic [2:0] f3, logic [31:0] rd);
    return {full, st, rq, w, ad, wd, f3, rd};
  endfunction

  function automatic logic [31:0] fmt(logic [31:0] word, logic [1:0] lane, logic [2:0] f3);
    logic [31:0] sb;
    logic [31:0] sh;
    sb = word >> (8 * lane);
    sh = word >> (16 * lane[1]);
    case (f3)
      3'b000:  return {{24{sb[7]}}, sb[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b010:  return word;
      3'b100:  return sb & 32'h0000_00FF;
      3'b101:  return sh & 32'h0000_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(logic [31:0] word, logic [31:0] wd,
    logic [1:0] lane, logic [2:0] f3);
    logic [31:0] r;
    r = word;
    case (f3)
      3'b000:  r[8*lane +: 8] = wd[7:0];
      3'b001:  r[16*lane[1] +: 16] = wd[15:0];
      3'b010:  r = wd;
      default: r = word;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, expv, $time);
    end
  endtask

  // scoreboard: one compare per cycle that has an expectation queued
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("stall", 32'(stall), 32'(e[101]));
      chk("mem_req", 32'(mem_req), 32'(e[100]));
      chk("RD", RD, e[31:0]);
      if (e[102] || e[100]) begin
        chk("mem_we", 32'(mem_we), 32'(e[99]));
        chk("mem_addr", mem_addr, e[98:67]);
        chk("mem_funct3", 32'(mem_funct3), 32'(e[34:32]));
      end
      if (e[102] || (e[100] && e[99])) chk("mem_wdata", mem_wdata, e[66:35]);
    end
  end

  task automatic samp(output bit s, output logic [31:0] r);
    @(negedge clk);
    s = stall;
    r = RD;
  endtask

  // driver: one CPU access; memory answers d cycles after mem_req rises
  task automatic op(input bit re, input bit we, input logic [31:0] a, input logic [31:0] wd,
    input logic [2:0] f3, input int d, output logic [31:0] rd_seen, output int stalls);
    logic [29:0] w;
    logic [31:0] word;
    int idx;
    bit hit;
    bit s;
    w = a[31:2];
    idx = int'(w[2:0]);
    if (!mem_m.exists(w)) mem_m[w] = $urandom;
    word = mem_m[w];
    hit = m_valid[idx] && (m_waddr[idx] == w);
    stalls = 0;
    @(posedge clk); #1;
    cpu_re = re; cpu_we = we; A = a; WD = wd; funct3 = f3;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    if (we) begin
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
      samp(s, rd_seen); stalls += int'(s);
      for (int i = 1; i <= d + 1; i++) begin
        @(posedge clk); #1;
        mem_ready = (i == d + 1);
        mem_rdata = $urandom;
        exp_q.push_back(mk(0, i != d + 1, 1, 1, a, wd, f3, 0));
        samp(s, rd_seen); stalls += int'(s);
      end
      mem_m[w] = st_merge(word, wd, a[1:0], f3);
    end else if (re && hit) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, fmt(word, a[1:0], f3)));
      samp(s, rd_seen); stalls += int'(s);
      m_hits++;
    end else if (re) begin
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
      samp(s, rd_seen); stalls += int'(s);
      for (int i = 1; i <= d + 1; i++) begin
        @(posedge clk); #1;
        mem_ready = (i == d + 1);
        mem_rdata = (i == d + 1) ? word : $urandom;
        exp_q.push_back(mk(0, i != d + 1, 1, 0, {a[31:2], 2'b00}, 0, 3'b010,
                           (i == d + 1) ? fmt(word, a[1:0], f3) : 32'h0));
        samp(s, rd_seen); stalls += int'(s);
      end
      m_misses++;
      m_valid[idx] = 1'b1;
      m_waddr[idx] = w;
    end else begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      samp(s, rd_seen); stalls += int'(s);
    end
  endtask

  logic [31:0] rd;
  logic [31:0] ra;
  int          st;
  int          kind;
  logic [2:0]  ld_f3 [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

  initial begin
    for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_waddr[i] = '0; end
    @(posedge clk); #1;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
`ifdef CACHE_STATS_EN
    chk("reset_hit_count", hit_count, 32'h0);
    chk("reset_miss_count", miss_count, 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    chk("pin_fmt_lb", fmt(32'hDEADBEEF, 2'd3, 3'b000), 32'hFFFFFFDE);
    chk("pin_merge_sb", st_merge(32'hDEADBEEF, 32'h55, 2'd1, 3'b000), 32'hDEAD55EF);

    // lw miss with a 3-cycle stall, then hit
    mem_m[30'h4] = 32'hDEADBEEF;
    op(1, 0, 32'h10, 0, 3'b010, 2, rd, st);
    chk("t1_miss_rd", rd, 32'hDEADBEEF);
    chk("t1_miss_stalls", 32'(st), 32'd3);
    op(1, 0, 32'h10, 0, 3'b010, 0, rd, st);
    chk("t1_hit_rd", rd, 32'hDEADBEEF);
    chk("t1_hit_stalls", 32'(st), 32'd0);

    // sub-word formatting on hits
    op(1, 0, 32'h13, 0, 3'b000, 0, rd, st); chk("t2_lb", rd, 32'hFFFFFFDE);
    op(1, 0, 32'h13, 0, 3'b100, 0, rd, st); chk("t2_lbu", rd, 32'h000000DE);
    op(1, 0, 32'h10, 0, 3'b001, 0, rd, st); chk("t2_lh", rd, 32'hFFFFBEEF);
    op(1, 0, 32'h12, 0, 3'b101, 0, rd, st); chk("t2_lhu", rd, 32'h0000DEAD);
    chk("t2_lhu_stalls", 32'(st), 32'd0);

    // sb hit merges into the line
    op(0, 1, 32'h11, 32'h55, 3'b000, 1, rd, st);
    chk("t3_sb_stalls", 32'(st), 32'd2);
    op(1, 0, 32'h10, 0, 3'b010, 0, rd, st);
    chk("t3_lw_rd", rd, 32'hDEAD55EF);
    chk("t3_lw_stalls", 32'(st), 32'd0);

    // store miss does not allocate
    op(0, 1, 32'h40, 32'h12345678, 3'b010, 0, rd, st);
    chk("t4_sw_stalls", 32'(st), 32'd1);
    op(1, 0, 32'h40, 0, 3'b010, 1, rd, st);
    chk("t4_lw_rd", rd, 32'h12345678);
    chk("t4_lw_stalls", 32'(st), 32'd2);

    // aliasing eviction
    op(1, 0, 32'h30, 0, 3'b010, 0, rd, st);
    chk("t5_alias_stalls", 32'(st), 32'd1);
    op(1, 0, 32'h10, 0, 3'b010, 0, rd, st);
    chk("t5_evicted_stalls", 32'(st), 32'd1);
    chk("t5_evicted_rd", rd, 32'hDEAD55EF);

    // reset while a refill of 0x30 waits
    @(posedge clk); #1;
    cpu_re = 1'b1; cpu_we = 1'b0; A = 32'h30; funct3 = 3'b010; mem_ready = 1'b0;
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(posedge clk); #1;
    exp_q.push_back(mk(0, 1, 1, 0, 32'h30, 0, 3'b010, 0));
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
`ifdef CACHE_STATS_EN
    chk("t6_hit_count", hit_count, 32'h0);
    chk("t6_miss_count", miss_count, 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b0; cpu_re = 1'b0;
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_hits = 0; m_misses = 0;
    op(1, 0, 32'h10, 0, 3'b010, 1, rd, st);
    chk("t6_after_rst_stalls", 32'(st), 32'd2);
    chk("t6_after_rst_rd", rd, 32'hDEAD55EF);

    // randomized traffic over a small address pool to get hits and aliases
    for (int k = 0; k < 400; k++) begin
      ra = {($urandom_range(0, 7) == 0) ? 4'hF : 4'h0, 21'h0, 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      kind = $urandom_range(0, 9);
      if (kind <= 4)
        op(1, 0, ra, $urandom, ld_f3[$urandom_range(0, 5)], $urandom_range(0, 3), rd, st);
      else if (kind <= 7)
        op(0, 1, ra, $urandom, 3'($urandom_range(0, 2)), $urandom_range(0, 3), rd, st);
      else if (kind == 8)
        op(1, 1, ra, $urandom, 3'($urandom_range(0, 2)), $urandom_range(0, 3), rd, st);
      else
        op(0, 0, ra, $urandom, 3'b010, 0, rd, st);
    end
    op(0, 0, 32'h0, 0, 3'b010, 0, rd, st);
`ifdef CACHE_STATS_EN
    chk("final_hit_count", hit_count, 32'(m_hits));
    chk("final_miss_count", miss_count, 32'(m_misses));
`endif
    @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
